// File: rtl/taillight_pkg.sv
// Shared types and lamp decode for the rear light cluster sequencer.
// Lamp vectors are ordered {la,lb,lc,ra,rb,rc}.
package taillight_pkg;

    typedef enum logic [2:0] {IDLE, L1, L2, L3, R1, R2, R3, HAZ} state_t;

    localparam logic [5:0] LAMPS_OFF   = 6'b000000;
    localparam logic [5:0] LAMPS_ALL   = 6'b111111;
    localparam logic [5:0] LAMPS_LEFT  = 6'b111000;
    localparam logic [5:0] LAMPS_RIGHT = 6'b000111;

    function automatic logic [5:0] lamp_decode(input state_t s);
        logic [5:0] l;
        l = LAMPS_OFF;
        case (s)
            L1:      l = 6'b100000;
            L2:      l = 6'b110000;
            L3:      l = 6'b111000;
            R1:      l = 6'b000100;
            R2:      l = 6'b000110;
            R3:      l = 6'b000111;
            HAZ:     l = LAMPS_ALL;
            default: l = LAMPS_OFF;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/taillight_tick_gen.sv
// Step prescaler: registered strobe high while the counter sits at TICK_DIV-1.
// Latency: strobe is a flop; with TICK_DIV=1 it goes high on the first edge after reset and stays high.
module tick_gen #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        count_nxt = (count == LAST) ? '0 : count + CNT_W'(1);
    end

    // tick tracks count_nxt so the flop is high exactly while count == LAST
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= count_nxt;
            tick  <= (count_nxt == LAST);
        end
    end

endmodule

// File: rtl/taillight_ctrl.sv
// Rear light sequencer: left/right turn sweeps and hazard blink, stepped on prescaled ticks; Moore lamp decode.
// Optional TAILLIGHT_BRAKE_EN adds a brake input forcing lamps not owned by the active sequence on.
module taillight_ctrl
    import taillight_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic hazard,
`ifdef TAILLIGHT_BRAKE_EN
    input  logic brake,
`endif
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic active,
    output logic tick
);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] lamps;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lamps     = lamp_decode(state);
        active    = (state != IDLE);

        if (tick) begin
            case (state)
                IDLE: begin
                    if (hazard || (left && right)) state_nxt = HAZ;
                    else if (left)                 state_nxt = L1;
                    else if (right)                state_nxt = R1;
                    else                           state_nxt = IDLE;
                end
                L1:      state_nxt = hazard ? HAZ : L2;
                L2:      state_nxt = hazard ? HAZ : L3;
                R1:      state_nxt = hazard ? HAZ : R2;
                R2:      state_nxt = hazard ? HAZ : R3;
                // L3/R3 always drop to IDLE so back-to-back sweeps show an all-off step
                L3:      state_nxt = IDLE;
                R3:      state_nxt = IDLE;
                HAZ:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

`ifdef TAILLIGHT_BRAKE_EN
        if (brake) begin
            case (state)
                IDLE:         lamps = LAMPS_ALL;
                L1, L2, L3:   lamps = lamps | LAMPS_RIGHT;
                R1, R2, R3:   lamps = lamps | LAMPS_LEFT;
                default:      lamps = lamps;
            endcase
        end
`endif
    end

    assign {la, lb, lc, ra, rb, rc} = lamps;

endmodule
